// File: rtl/tag_lookup_ctrl_2way_pkg.sv
// tag_lookup_ctrl_2way_pkg: shared state encoding and address/entry field positions
package tag_lookup_ctrl_2way_pkg;
   localparam int AWIDTH_DEF = 3;
   localparam int TWIDTH_DEF = 13;
   localparam int OWIDTH_DEF = 4;
   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_LOOKUP,
      S_MISS_REQ,
      S_REFILL,
      S_RESP
   } state_t;
   function automatic int valid_bit(input int twidth);
      return twidth;
   endfunction
   function automatic int idx_lsb(input int owidth);
      return owidth;
   endfunction
   function automatic int tag_lsb(input int owidth, input int awidth);
      return owidth + awidth;
   endfunction
endpackage

// File: rtl/tag_lookup_ctrl_2way_tag_compare.sv
// tag_compare_2way: per-way hit detection, hit-way select and refill victim choice
module tag_compare_2way
   import tag_lookup_ctrl_2way_pkg::*;
#(
   parameter int TWIDTH = TWIDTH_DEF,
   localparam int DWIDTH = TWIDTH + 1
) (
   input  logic [DWIDTH-1:0] dout0,
   input  logic [DWIDTH-1:0] dout1,
   input  logic [TWIDTH-1:0] tag,
   input  logic              lru,
   output logic              hit0,
   output logic              hit1,
   output logic              way,
   output logic              victim
);
   localparam int VB = valid_bit(TWIDTH);
   assign hit0 = dout0[VB] & (dout0[TWIDTH-1:0] == tag);
   assign hit1 = dout1[VB] & (dout1[TWIDTH-1:0] == tag);
   assign way = ~hit0;
   // empty ways are filled before any valid line is evicted
   assign victim = ~dout0[VB] ? 1'b0 : ~dout1[VB] ? 1'b1 : lru;
endmodule

// File: rtl/tag_lookup_ctrl_2way.sv
// tag_lookup_ctrl_2way: 2-way tag lookup, miss request and refill controller with per-set LRU
module tag_lookup_ctrl_2way
   import tag_lookup_ctrl_2way_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int TWIDTH = TWIDTH_DEF,
   parameter int OWIDTH = OWIDTH_DEF,
   localparam int DWIDTH = TWIDTH + 1,
   localparam int PAWIDTH = TWIDTH + AWIDTH + OWIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid,
   input  logic [PAWIDTH-1:0] req_addr,
   output logic               req_ready,
   output logic               resp_valid,
   output logic               resp_hit,
   output logic               resp_way,
   output logic [AWIDTH-1:0]  tag_addr,
   output logic [DWIDTH-1:0]  tag_din,
   output logic               tag_we0,
   output logic               tag_we1,
   input  logic [DWIDTH-1:0]  tag_dout0,
   input  logic [DWIDTH-1:0]  tag_dout1,
   output logic               mem_req,
   output logic [PAWIDTH-1:0] mem_addr,
   input  logic               mem_ready,
   output logic               init_done
);
   localparam int DEPTH = 1 << AWIDTH;
   localparam int IL = idx_lsb(OWIDTH);
   localparam int TL = tag_lsb(OWIDTH, AWIDTH);
   state_t state;
   logic [AWIDTH-1:0] cnt;
   logic [AWIDTH-1:0] idx_q;
   logic [TWIDTH-1:0] tag_q;
   logic [DEPTH-1:0] lru;
   logic victim_q;
   logic hit_q;
   logic way_q;
   logic hit0;
   logic hit1;
   logic way;
   logic victim;
   logic unused_offset;
   assign unused_offset = &{1'b0, req_addr[OWIDTH-1:0]};
   tag_compare_2way #(.TWIDTH(TWIDTH)) u_cmp (
      .dout0(tag_dout0),
      .dout1(tag_dout1),
      .tag(tag_q),
      .lru(lru[idx_q]),
      .hit0(hit0),
      .hit1(hit1),
      .way(way),
      .victim(victim)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_INIT;
         cnt <= '0;
         lru <= '0;
         hit_q <= 1'b0;
         way_q <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == AWIDTH'(DEPTH - 1)) state <= S_IDLE;
            end
            S_IDLE: if (req_valid) begin
               tag_q <= req_addr[TL +: TWIDTH];
               idx_q <= req_addr[IL +: AWIDTH];
               state <= S_LOOKUP;
            end
            S_LOOKUP: if (hit0 | hit1) begin
               lru[idx_q] <= ~way;
               hit_q <= 1'b1;
               way_q <= way;
               state <= S_RESP;
            end else begin
               victim_q <= victim;
               state <= S_MISS_REQ;
            end
            S_MISS_REQ: if (mem_ready) state <= S_REFILL;
            S_REFILL: begin
               lru[idx_q] <= ~victim_q;
               hit_q <= 1'b0;
               way_q <= victim_q;
               state <= S_RESP;
            end
            S_RESP: state <= S_IDLE;
            default: state <= S_INIT;
         endcase
      end
   end
   // every output is forced low while reset is held, even before the first edge
   assign req_ready = ~reset & (state == S_IDLE);
   assign resp_valid = ~reset & (state == S_RESP);
   assign resp_hit = ~reset & hit_q;
   assign resp_way = ~reset & way_q;
   assign tag_addr = reset ? '0 : (state == S_INIT) ? cnt : (state == S_IDLE) ? req_addr[IL +: AWIDTH] : idx_q;
   assign tag_din = (~reset & (state == S_REFILL)) ? {1'b1, tag_q} : '0;
   assign tag_we0 = ~reset & ((state == S_INIT) | ((state == S_REFILL) & ~victim_q));
   assign tag_we1 = ~reset & ((state == S_INIT) | ((state == S_REFILL) & victim_q));
   assign mem_req = ~reset & (state == S_MISS_REQ);
   assign mem_addr = mem_req ? {tag_q, idx_q, {OWIDTH{1'b0}}} : '0;
   assign init_done = ~reset & (state != S_INIT);
endmodule
